// File: rtl/host_cmd_pkg.sv
// Shared definitions for the host command driver: FSM states, register map
// and control-register bit positions.
package host_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    LAUNCH,
    POLL_REQ,
    POLL_RESP,
    CLEAR,
    DONE
  } state_t;

  localparam logic [7:0] CTRL   = 8'h00;
  localparam logic [7:0] LEN    = 8'h04;
  localparam logic [7:0] INP_LO = 8'h08;
  localparam logic [7:0] INP_HI = 8'h0c;
  localparam logic [7:0] OUT_LO = 8'h10;
  localparam logic [7:0] OUT_HI = 8'h14;

  localparam int LAUNCH_BIT = 0;
  localparam int FINISH_BIT = 1;

  localparam logic [2:0] LAST_WR_IDX = 3'd4;

  // Job-programming writes target consecutive words starting at LEN.
  function automatic logic [7:0] wr_addr(input logic [2:0] idx);
    return LEN + 8'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/host_req_port.sv
// Registered host request stage (loaded once, held until dequeued) plus the
// read-response qualifier that extracts the finish bit.
module host_req_port
  import host_cmd_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 load_opcode,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [DATA_BITS-1:0] load_value,
  input  logic                 req_deq,
  output logic                 req_valid,
  output logic                 req_opcode,
  output logic [ADDR_BITS-1:0] req_addr,
  output logic [DATA_BITS-1:0] req_value,
  output logic                 req_fire,
  input  logic                 resp_en,
  input  logic                 resp_valid,
  input  logic [DATA_BITS-1:0] resp_bits,
  output logic                 resp_fire,
  output logic                 resp_finish
);

  assign req_fire = req_valid & req_deq;

  // NOTE: asynchronous reset drops a pending request at once; it is never replayed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_valid  <= 1'b0;
      req_opcode <= 1'b0;
      req_addr   <= '0;
      req_value  <= '0;
    end else if (load) begin
      req_valid  <= 1'b1;
      req_opcode <= load_opcode;
      req_addr   <= load_addr;
      req_value  <= load_value;
    end else if (req_fire) begin
      req_valid  <= 1'b0;
    end
  end

  // Only the finish bit of a polled value carries meaning.
  assign resp_fire   = resp_en & resp_valid;
  assign resp_finish = resp_bits[FINISH_BIT];

  logic unused_resp_bits;
  assign unused_resp_bits = ^resp_bits;

endmodule

// File: rtl/host_cmd_driver.sv
// Host-side job initiator: programs length/pointers, launches, polls finish,
// clears control. Optional poll watchdog: HOST_CMD_DRIVER_TIMEOUT_EN.
module host_cmd_driver
  import host_cmd_pkg::*;
#(
  parameter int MEM_ADDR_BITS  = 64,
  parameter int HOST_ADDR_BITS = 8,
  parameter int HOST_DATA_BITS = 32,
  parameter int CYCLE_BITS     = 32,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [HOST_DATA_BITS-1:0] job_length,
  input  logic [MEM_ADDR_BITS-1:0]  job_inp_baddr,
  input  logic [MEM_ADDR_BITS-1:0]  job_out_baddr,
  output logic                      host_req_valid,
  output logic                      host_req_opcode,
  output logic [HOST_ADDR_BITS-1:0] host_req_addr,
  output logic [HOST_DATA_BITS-1:0] host_req_value,
  input  logic                      host_req_deq,
  input  logic                      host_resp_valid,
  input  logic [HOST_DATA_BITS-1:0] host_resp_bits,
  output logic                      done,
  output logic [CYCLE_BITS-1:0]     cycles,
  output logic                      error
);

  if (MEM_ADDR_BITS != 64 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("host_cmd_driver: MEM_ADDR_BITS must be 64 and TIMEOUT_CYCLES positive");
  end

  state_t                    state, state_nxt;
  logic [2:0]                wr_idx;
  logic [HOST_DATA_BITS-1:0] len_q;
  logic [MEM_ADDR_BITS-1:0]  inp_q, out_q;
  logic                      req_load, req_load_op;
  logic [HOST_ADDR_BITS-1:0] req_load_addr;
  logic [HOST_DATA_BITS-1:0] req_load_value;
  logic                      req_fire, resp_fire, resp_finish;
  logic                      polling, timed_out;

  assign polling   = (state == POLL_REQ) || (state == POLL_RESP);
  assign job_ready = (state == IDLE);
  assign done      = (state == DONE);

  host_req_port #(
    .ADDR_BITS(HOST_ADDR_BITS),
    .DATA_BITS(HOST_DATA_BITS)
  ) u_req_port (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (req_load),
    .load_opcode(req_load_op),
    .load_addr  (req_load_addr),
    .load_value (req_load_value),
    .req_deq    (host_req_deq),
    .req_valid  (host_req_valid),
    .req_opcode (host_req_opcode),
    .req_addr   (host_req_addr),
    .req_value  (host_req_value),
    .req_fire   (req_fire),
    .resp_en    (state == POLL_RESP),
    .resp_valid (host_resp_valid),
    .resp_bits  (host_resp_bits),
    .resp_fire  (resp_fire),
    .resp_finish(resp_finish)
  );

  // A request is loaded whenever a requesting state has nothing in flight;
  // every dequeue changes state or write index, so each is issued once.
  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_nxt      = state;
    req_load       = 1'b0;
    req_load_op    = 1'b1;
    req_load_addr  = HOST_ADDR_BITS'(CTRL);
    req_load_value = '0;
    case (state)
      IDLE: if (job_valid) state_nxt = WR;
      WR: begin
        req_load      = !host_req_valid;
        req_load_addr = HOST_ADDR_BITS'(wr_addr(wr_idx));
        case (wr_idx)
          3'd0:    req_load_value = len_q;
          3'd1:    req_load_value = HOST_DATA_BITS'(inp_q[31:0]);
          3'd2:    req_load_value = HOST_DATA_BITS'(inp_q[63:32]);
          3'd3:    req_load_value = HOST_DATA_BITS'(out_q[31:0]);
          default: req_load_value = HOST_DATA_BITS'(out_q[63:32]);
        endcase
        if (req_fire && wr_idx == LAST_WR_IDX) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        req_load       = !host_req_valid;
        req_load_value = HOST_DATA_BITS'(1 << LAUNCH_BIT);
        if (req_fire) state_nxt = POLL_REQ;
      end
      POLL_REQ: begin
        if (timed_out && !host_req_valid) begin
          state_nxt = CLEAR;
        end else begin
          req_load    = !host_req_valid;
          req_load_op = 1'b0;
          if (req_fire) state_nxt = POLL_RESP;
        end
      end
      POLL_RESP: if (resp_fire) state_nxt = (resp_finish || timed_out) ? CLEAR : POLL_REQ;
      CLEAR: begin
        req_load = !host_req_valid;
        if (req_fire) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      wr_idx <= '0;
      len_q  <= '0;
      inp_q  <= '0;
      out_q  <= '0;
      cycles <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        wr_idx <= '0;
        if (job_valid) begin
          len_q <= job_length;
          inp_q <= job_inp_baddr;
          out_q <= job_out_baddr;
        end
      end else if (state == WR && req_fire) begin
        wr_idx <= wr_idx + 3'd1;
      end
      if (state == LAUNCH && req_fire)
        cycles <= '0;
      else if (polling && cycles != '1 && !timed_out)
        cycles <= cycles + 1'b1;
    end
  end

`ifdef HOST_CMD_DRIVER_TIMEOUT_EN
  // The poll-phase counter doubles as the watchdog and freezes at the limit.
  assign timed_out = (cycles == CYCLE_BITS'(TIMEOUT_CYCLES));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 error <= 1'b0;
    else if (polling && timed_out) error <= 1'b1;
  end
`else
  assign timed_out = 1'b0;
  assign error     = 1'b0;
`endif

endmodule

// File: doc/host_cmd_driver.md
Name: host_cmd_driver

Overview:
- Host-side initiator for the host register interface (host_req / host_resp) of the tsim accelerator register file.
- Accepts one job descriptor (length, input base, output base) per valid/ready handshake and programs the length and pointer registers with write requests.
- Pulses launch via the control register, then polls the control register until the finish bit is set.
- Clears the control register and reports completion with the measured launch-to-finish cycle count.

Parameters:
- MEM_ADDR_BITS, 64, width of the input/output base pointers; must be 64 (split into two 32-bit halves).
- HOST_ADDR_BITS, 8, width of the host request address.
- HOST_DATA_BITS, 32, width of host request/response data.
- CYCLE_BITS, 32, width of the launch-to-finish cycle counter.
- TIMEOUT_CYCLES, 65536, poll timeout; used only with HOST_CMD_DRIVER_TIMEOUT_EN.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- job_valid  in  1  job descriptor valid.
- job_ready  out  1  driver idle; job accepted when job_valid & job_ready.
- job_length  in  HOST_DATA_BITS  element count.
- job_inp_baddr  in  MEM_ADDR_BITS  input base address.
- job_out_baddr  in  MEM_ADDR_BITS  output base address.
- host_req_valid  out  1  request valid.
- host_req_opcode  out  1  1 = write, 0 = read.
- host_req_addr  out  HOST_ADDR_BITS  register byte address.
- host_req_value  out  HOST_DATA_BITS  write data.
- host_req_deq  in  1  responder accepted the request this cycle.
- host_resp_valid  in  1  read data valid (one-cycle pulse).
- host_resp_bits  in  HOST_DATA_BITS  read data.
- done  out  1  one-cycle completion pulse.
- cycles  out  CYCLE_BITS  launch-to-finish count; held until the next launch.
- error  out  1  sticky timeout flag (feature only; constant 0 otherwise).

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; job_ready=1; host_req_valid=0; opcode/addr/value=0.
  - done=0; cycles=0; error=0.
  - Reset mid-transaction abandons the request immediately; nothing is replayed.
- Job acceptance: on job_valid & job_ready, latch the three job fields; job_ready=0 from the next cycle until DONE.
- Request handshake:
  - host_req_valid, opcode, addr and value are registered and held stable until the cycle host_req_deq=1.
  - The next request is driven no earlier than the following cycle.
  - Reads: after the deq cycle, wait for host_resp_valid and sample host_resp_bits in that cycle.
  - A host_resp_valid pulse in any other state is ignored.
- State machine:
  - IDLE -> WR on job accept.
  - WR: five writes in order, advancing on each deq:
    - 0x04 = length
    - 0x08 = inp[31:0]
    - 0x0c = inp[63:32]
    - 0x10 = out[31:0]
    - 0x14 = out[63:32]
  - LAUNCH: write 0x00 = 1. On deq: clear cycles to 0, go to POLL_REQ.
  - POLL_REQ: read 0x00; on deq go to POLL_RESP.
  - POLL_RESP: on host_resp_valid, if bit1 (finish) = 1 go to CLEAR, else go to POLL_REQ.
  - CLEAR: write 0x00 = 0; on deq go to DONE.
  - DONE: done=1 for one cycle, job_ready=1, then IDLE.
- Cycle counter:
  - Increments every cycle in POLL_REQ and POLL_RESP.
  - Saturates at all-ones and does not wrap.
- Bit 0 (launch) in a polled value is ignored; only bit 1 matters.
- job_valid asserted while not ready has no effect.
- deq and resp_valid arriving in the same cycle as a state change are handled only per the current state's rule.

Optional Feature:
- Macro: HOST_CMD_DRIVER_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in POLL_REQ/POLL_RESP.
  - When the count reaches TIMEOUT_CYCLES with finish not yet seen, set error=1 (sticky until reset).
  - Then proceed to CLEAR, once any outstanding read response has been received.
  - done still pulses; cycles = TIMEOUT_CYCLES.
- Undefined: no watchdog; polling is unbounded; error is tied to 0.

Decomposition:
- Package host_cmd_pkg holds:
  - state_t enum: IDLE, WR, LAUNCH, POLL_REQ, POLL_RESP, CLEAR, DONE.
  - Register address constants: CTRL=0x00, LEN=0x04, INP_LO=0x08, INP_HI=0x0c, OUT_LO=0x10, OUT_HI=0x14.
  - Control bit indices: LAUNCH_BIT=0, FINISH_BIT=1.
- One sub-module, host_req_port: registered request holding stage (load/hold until deq) plus read-response capture.

Test Plan:
- Job len=0x10, inp=0x0000_0001_0000_2000, out=0x0000_0002_0000_4000, responder deq immediately:
  - Writes seen in order: 0x04=0x10, 0x08=0x2000, 0x0c=0x1, 0x10=0x4000, 0x14=0x2, 0x00=0x1.
- Backpressure, deq held low 3 cycles per request:
  - addr, value and opcode stay stable across the stall.
  - No request is skipped or duplicated.
- Poll: responder returns 0x1 twice, then 0x2:
  - Exactly three reads of 0x00, then write 0x00=0.
  - done pulses once; cycles equals the poll-phase cycle count.
- job_valid held high through a whole job:
  - Second job accepted only the cycle after done.
  - job_ready=0 throughout the first job.
- reset_n asserted during POLL_RESP:
  - Same cycle: host_req_valid=0, job_ready=1, cycles=0, done=0.
  - After release, a new job executes normally.
- With HOST_CMD_DRIVER_TIMEOUT_EN and TIMEOUT_CYCLES=64, responder never sets finish:
  - error=1, write 0x00=0, done pulses, cycles=64.
